rev_rr_sched: RTL
=================

Name: rev_rr_sched

Overview:
- Shares one W-bit bit-reversal datapath between N requesters using round-robin arbitration.
- Each requester presents a word under a valid/ready handshake.
- The winning word is reversed (bit i of the result = bit W-1-i of the input) and captured in a one-entry output register, tagged with the requester index.
- Sits between multiple producer blocks and a single downstream consumer with valid/ready backpressure.

Parameters:
- W, 16, data word width in bits (W >= 1).
- N, 4, number of requesters (N >= 2).
- IDW, $clog2(N), width of the requester index tag (derived; not overridden).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- req_valid  input  N  bit i: requester i presents a word.
- req_data  input  N*W  requester i word on bits [i*W +: W].
- req_ready  output  N  bit i: requester i's word is accepted this cycle (one-hot or zero).
- out_valid  output  1  output register holds a result.
- out_data  output  W  bit-reversed word.
- out_id  output  IDW  index of the requester that supplied out_data.
- out_ready  input  1  consumer accepts the result this cycle.
- xfer_cnt  output  16  count of completed output transfers; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (async, immediate):
  - state=EMPTY, out_valid=0, out_data=0, out_id=0, ptr=0, xfer_cnt=0.
  - req_ready is all-zero while rst is high.
- States:
  - EMPTY: output register invalid, out_valid=0.
  - FULL: output register valid, out_valid=1.
- Accept condition: can_accept = (state==EMPTY) | (state==FULL & out_ready).
- Grant (combinational):
  - Scan req_valid starting at index ptr, ascending, wrapping N-1 -> 0.
  - The first asserted index g wins.
  - req_ready = onehot(g) when can_accept and any req_valid; otherwise 0.
  - A requester's handshake completes when req_valid[i] & req_ready[i].
- On a grant, at the clock edge:
  - out_data <= reverse(req_data[g]).
  - out_id <= g.
  - ptr <= (g+1) mod N.
  - state <= FULL.
- Latency: a word accepted in cycle T appears on out_data/out_valid in cycle T+1.
- Throughput: one word per cycle when out_ready is held high.
- Transitions:
  - EMPTY, no request: stay EMPTY.
  - EMPTY, request: go FULL.
  - FULL, out_ready=0: hold. out_data and out_id are stable, no grant, ptr unchanged.
  - FULL, out_ready=1, request: stay FULL and reload (simultaneous drain and fill).
  - FULL, out_ready=1, no request: go EMPTY. out_data and out_id retain their last value.
- ptr changes only on a grant. With no requests it holds.
- xfer_cnt increments on each out_valid & out_ready edge.
- A single requester held valid is granted every accept cycle (ptr wraps past it and returns).
- Fairness: any continuously valid requester is granted within N accept cycles.
- req_data of non-granted requesters is ignored. Inputs may change freely when not granted.
- Reset asserted mid-transfer discards the held result. No req_ready pulse is issued in the reset-release cycle before the first clk edge.
- N not a power of two: ptr wraps at N, not at 2^IDW. Unused out_id codes never appear.

Test Plan:
- Reset, then requester 0 presents 16'b1000000001111000 with out_ready=1.
  - Expect req_ready=0001 in the same cycle.
  - Next cycle: out_valid=1, out_data=16'b0001111000000001, out_id=0, xfer_cnt increments.
- All four requesters valid, out_ready=1, data 16'hF000/16'h8007/16'h0001/16'h8000 on req 0..3.
  - Expect grant order 0,1,2,3,0.
  - Expect outputs 16'h000F, 16'hE001, 16'h8000, 16'h0001.
- Backpressure: out_ready=0 for 5 cycles with req 1 and 2 valid.
  - Expect out_valid=1 and stable out_data/out_id, req_ready=0, ptr unchanged.
  - Raise out_ready: expect drain and fill in the same cycle, next grant = next index after the held out_id.
- Drain with no requests:
  - Expect out_valid to drop the cycle after the out_ready handshake.
  - A later single request to req 3 returns 16'b1110000000000001 for input 16'b1000000000000111.
- Assert rst while FULL with out_ready=0.
  - Expect immediate out_valid=0, xfer_cnt=0, ptr=0.
  - First post-reset grant goes to the lowest valid index.
- Parameter sweep W=1, W=7, N=3, random traffic for 10k cycles.
  - Scoreboard: every accepted word appears exactly once, reversed, with the correct id.
  - No requester starved beyond N accept cycles.
  - xfer_cnt equals the handshake count mod 2^16.

Source files
------------

// File: rtl/rev_rr_sched_if.sv
// Handshake bundle for rev_rr_sched: N valid/ready producer lanes in, one
// tagged valid/ready result out, plus the running transfer count.
interface rev_rr_sched_if #(
  parameter int W = 16,
  parameter int N = 4
);
  localparam int IDW = $clog2(N);

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [IDW-1:0] out_id;
  logic           out_ready;
  logic [15:0]    xfer_cnt;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, xfer_cnt
  );

  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, xfer_cnt
  );
endinterface

// File: rtl/rev_rr_sched.sv
// Round-robin arbiter feeding a shared bit-reversal datapath into a one-entry
// tagged output register with valid/ready backpressure.
module rev_rr_sched #(
  parameter int W = 16,
  parameter int N = 4
) (
  input logic           clk,
  input logic           rst,
  rev_rr_sched_if.slave bus
);
  localparam int IDW = $clog2(N);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t         state_reg;
  logic [IDW-1:0] ptr_reg;
  logic [IDW-1:0] id_reg;
  logic [W-1:0]   data_reg;
  logic [15:0]    xfer_reg;
  logic           run_reg;

  logic           can_accept;
  logic           any_req;
  logic           grant;
  logic [IDW-1:0] grant_idx;
  int             scan_idx;
  logic [W-1:0]   sel_word;
  logic [W-1:0]   rev_word;
  logic [N-1:0]   grant_onehot;

  // run_reg keeps req_ready low from reset release until the first clock edge.
  assign can_accept = run_reg && ((state_reg == EMPTY) || bus.out_ready);

  always_comb begin
    any_req   = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_reg) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!any_req && bus.req_valid[scan_idx]) begin
        any_req   = 1'b1;
        grant_idx = IDW'(scan_idx);
      end
    end
  end

  assign grant    = can_accept && any_req;
  assign sel_word = bus.req_data[int'(grant_idx)*W +: W];

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign rev_word[gi] = sel_word[W-1-gi];
    end
    for (genvar gi = 0; gi < N; gi++) begin : g_ready
      assign grant_onehot[gi] = grant && (grant_idx == IDW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= EMPTY;
      ptr_reg   <= '0;
      id_reg    <= '0;
      data_reg  <= '0;
      xfer_reg  <= '0;
      run_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if ((state_reg == FULL) && bus.out_ready)
        xfer_reg <= xfer_reg + 16'd1;
      if (grant) begin
        data_reg  <= rev_word;
        id_reg    <= grant_idx;
        // Explicit wrap so non-power-of-two N never produces unused codes.
        ptr_reg   <= (grant_idx == IDW'(N-1)) ? '0 : grant_idx + 1'b1;
        state_reg <= FULL;
      end else if ((state_reg == FULL) && bus.out_ready) begin
        state_reg <= EMPTY;
      end
    end
  end

  assign bus.req_ready = grant_onehot;
  assign bus.out_valid = (state_reg == FULL);
  assign bus.out_data  = data_reg;
  assign bus.out_id    = id_reg;
  assign bus.xfer_cnt  = xfer_reg;
endmodule
